fdivsqrt_sched: RTL
===================

Name: fdivsqrt_sched

Overview:
Shares one fdivsqrt unit (iterative div/sqrt, one operation in flight) between NREQ requesters, e.g. two FP issue ports.
- Arbitrates round-robin and latches the winner's operands.
- Issues a single-cycle valid to the unit, waits for finish, then buffers the result in a response register until the consumer accepts it.
- Supports flush, with discard of the in-flight result.

Parameters:
- EXPWIDTH, 8, exponent width (matches fdivsqrt).
- SIGWIDTH, 24, significand width incl. hidden bit; FW = EXPWIDTH+SIGWIDTH.
- NREQ, 2, number of requesters (2..4).
- TAGW, 4, requester-supplied tag width.
- WDOG, 255, max cycles in WAIT before err_timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  one-hot grant/accept.
- req_frs1, req_frs2  in  NREQ*FW  packed operands, requester i at [i*FW +: FW].
- req_ftype  in  NREQ  1 = sqrt (frs1 only), 0 = divide.
- req_rm  in  NREQ*3  rounding mode.
- req_tag  in  NREQ*TAGW  opaque tag.
- cfg_fcontrol  in  1  tininess control, sampled at accept.
- flush  in  1  discard pending/in-flight op.
- du_frs1, du_frs2  out  FW  unit operands (registered).
- du_ftype, du_fcontrol  out  1  registered.
- du_rm  out  3  registered.
- du_valid_in  out  1  issue strobe.
- du_ready_out  in  1  unit can accept.
- du_finish  in  1  one-cycle result-valid pulse.
- du_res  in  FW  result.
- du_flags  in  5  {NV,DZ,OF,UF,NX}.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  $clog2(NREQ)  originating requester.
- rsp_tag  out  TAGW  echoed tag.
- rsp_res  out  FW  result.
- rsp_flags  out  5  exception flags.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky watchdog error.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rr_ptr=0; all du_* and rsp_* outputs 0; err_timeout=0; wdog=0.
- FSM states: IDLE, ISSUE, WAIT, DRAIN, RESP.
- IDLE:
  - req_ready is combinational: one-hot to the first valid requester at or after rr_ptr (wrapping), only when du_ready_out=1 and flush=0.
  - On handshake: latch operands, ftype, rm, tag, id and cfg_fcontrol; go to ISSUE.
- ISSUE: du_valid_in=1 while du_ready_out=1. The unit samples when both are 1; du_valid_in then drops and state -> WAIT. du_valid_in is never high more than one cycle per op.
- WAIT:
  - Each cycle wdog++.
  - On du_finish: latch du_res and du_flags into rsp_*; set rsp_valid=1; state -> RESP.
  - If wdog reaches WDOG: set err_timeout (sticky until reset); state stays WAIT.
- RESP:
  - rsp_valid held with all rsp_* stable until rsp_ready=1.
  - On accept: rsp_valid=0; rr_ptr = rsp_id+1 mod NREQ; state -> IDLE.
  - A new accept is allowed no earlier than the next cycle.
- Flush:
  - IDLE: no grant.
  - ISSUE or WAIT: the unit cannot abort, so state -> DRAIN. If du_finish coincides with flush, the result is discarded.
  - DRAIN: ignore everything until du_finish, then IDLE; no response is produced.
  - RESP: rsp_valid cleared, state -> IDLE.
- du_finish outside WAIT/DRAIN is ignored.
- rsp_ready with rsp_valid=0 has no effect.
- Latency: accept at T; du_valid_in at T+1 (if du_ready_out); rsp_valid the cycle after du_finish.
- Max throughput: one op per unit latency + 3 cycles.
- Reset mid-operation: returns to IDLE immediately. The unit shares reset, so no drain is needed.

Decomposition:
- Package fdivsqrt_pkg:
  - EXPWIDTH/SIGWIDTH defaults and the FW macro.
  - State encoding localparams.
  - Flag bit indices: NV=4, DZ=3, OF=2, UF=1, NX=0.
  - Rounding-mode constants: RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4.
- One sub-module: rr_arbiter (NREQ-wide, inputs req/ptr/enable, output one-hot grant plus encoded index). Reusable by the future fma scheduler.

Test Plan:
1. Requester 0: divide 0x40C00000 / 0x40000000, rm=0, tag=5 -> one du_valid_in pulse; rsp_res=0x40400000, rsp_flags=0, rsp_id=0, rsp_tag=5.
2. Requester 1: sqrt 0x40800000 -> rsp_res=0x40000000, flags=0. Divide 0x3F800000 / 0x00000000 -> rsp_res=0x7F800000, flags=5'b01000.
3. Both req_valid held for 4 ops -> grant order 0,1,0,1. No req_ready while busy.
4. rsp_ready=0 for 10 cycles after finish -> rsp_* stable, busy=1, no new grant. rsp_ready=1 -> IDLE next cycle.
5. Flush in WAIT -> DRAIN, du_finish produces no rsp_valid. Next op (divide 0x41200000 / 0x40A00000) -> 0x40000000.
6. du_finish suppressed with WDOG=16 -> err_timeout=1 after 16 WAIT cycles. rst_n low mid-WAIT -> all outputs 0 asynchronously, err_timeout cleared.

Source files
------------

// File: rtl/fdivsqrt_pkg.sv
// fdivsqrt_pkg: shared widths, FSM encoding, flag indices and rounding modes for the fdivsqrt scheduler
`define FDIVSQRT_FW(e, s) ((e) + (s))

package fdivsqrt_pkg;
    localparam int EXPWIDTH_DEF = 8;
    localparam int SIGWIDTH_DEF = 24;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or after ptr_i (wrapping)
//   req_i  : per-requester request
//   ptr_i  : highest-priority requester index
//   en_i   : when low no grant is produced
//   gnt_o  : one-hot grant, idx_o its encoded index, vld_o any grant
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    // Rotate so bit 0 is the requester at ptr_i; scanning downwards lets the
    // lowest rotated offset win.
    always_comb begin
        dbl   = {req_i, req_i} >> ptr_i;
        rot   = dbl[N-1:0];
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = N - 1; k >= 0; k--)
            if (rot[k] && en_i) begin
                vld_o = 1'b1;
                idx_o = IW'((int'(ptr_i) + k) % N);
            end
        gnt_o = vld_o ? N'(1) << idx_o : '0;
    end
endmodule

// File: rtl/fdivsqrt_sched.sv
// fdivsqrt_sched: shares one iterative div/sqrt unit between NREQ requesters
//   req_*        : requester side, packed per requester (i at [i*W +: W]); req_ready is the one-hot grant
//   cfg_fcontrol : tininess control, captured with the operands
//   flush        : drops the pending/in-flight op; an in-flight result is drained and discarded
//   du_*         : unit side; du_valid_in is a single-cycle issue strobe
//   rsp_*        : buffered result, held until rsp_ready
//   busy         : scheduler not idle; err_timeout : sticky watchdog error in WAIT
module fdivsqrt_sched
    import fdivsqrt_pkg::*;
#(
    parameter int EXPWIDTH = EXPWIDTH_DEF,
    parameter int SIGWIDTH = SIGWIDTH_DEF,
    parameter int NREQ     = 2,
    parameter int TAGW     = 4,
    parameter int WDOG     = 255,
    localparam int FW      = `FDIVSQRT_FW(EXPWIDTH, SIGWIDTH),
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*FW-1:0] req_frs1,
    input  logic [NREQ*FW-1:0] req_frs2,
    input  logic [NREQ-1:0]    req_ftype,
    input  logic [NREQ*3-1:0]  req_rm,
    input  logic [NREQ*TAGW-1:0] req_tag,
    input  logic               cfg_fcontrol,
    input  logic               flush,
    output logic [FW-1:0]      du_frs1,
    output logic [FW-1:0]      du_frs2,
    output logic               du_ftype,
    output logic               du_fcontrol,
    output logic [2:0]         du_rm,
    output logic               du_valid_in,
    input  logic               du_ready_out,
    input  logic               du_finish,
    input  logic [FW-1:0]      du_res,
    input  logic [4:0]         du_flags,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [TAGW-1:0]    rsp_tag,
    output logic [FW-1:0]      rsp_res,
    output logic [4:0]         rsp_flags,
    output logic               busy,
    output logic               err_timeout
);
    localparam int WW = $clog2(WDOG + 1);

    logic [2:0]      state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d, id_q, id_d, rsp_id_q, rsp_id_d;
    logic [TAGW-1:0] tag_q, tag_d, rsp_tag_q, rsp_tag_d;
    logic [FW-1:0]   frs1_q, frs1_d, frs2_q, frs2_d, rsp_res_q, rsp_res_d;
    logic            ftype_q, ftype_d, fctl_q, fctl_d;
    logic [2:0]      rm_q, rm_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [4:0]      rsp_flags_q, rsp_flags_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic            err_q, err_d;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_vld;

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (state_q == S_IDLE && du_ready_out && !flush),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    assign req_ready   = gnt;
    assign du_frs1     = frs1_q;
    assign du_frs2     = frs2_q;
    assign du_ftype    = ftype_q;
    assign du_fcontrol = fctl_q;
    assign du_rm       = rm_q;
    // The unit samples on valid&ready, so gating with ready keeps the strobe to one sampled cycle.
    assign du_valid_in = state_q == S_ISSUE && du_ready_out;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_res     = rsp_res_q;
    assign rsp_flags   = rsp_flags_q;
    assign busy        = state_q != S_IDLE;
    assign err_timeout = err_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        tag_d       = tag_q;
        frs1_d      = frs1_q;
        frs2_d      = frs2_q;
        ftype_d     = ftype_q;
        fctl_d      = fctl_q;
        rm_d        = rm_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;
        wdog_d      = wdog_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: if (gnt_vld) begin
                id_d    = gnt_idx;
                tag_d   = req_tag[gnt_idx*TAGW +: TAGW];
                frs1_d  = req_frs1[gnt_idx*FW +: FW];
                frs2_d  = req_frs2[gnt_idx*FW +: FW];
                ftype_d = req_ftype[gnt_idx];
                rm_d    = req_rm[gnt_idx*3 +: 3];
                fctl_d  = cfg_fcontrol;
                state_d = S_ISSUE;
            end
            // A flushed op the unit already took must be drained; one it never saw is simply dropped.
            S_ISSUE: if (flush) state_d = du_ready_out ? S_DRAIN : S_IDLE;
                else if (du_ready_out) begin
                    wdog_d  = '0;
                    state_d = S_WAIT;
                end
            S_WAIT: begin
                wdog_d = wdog_q == WW'(WDOG) ? wdog_q : wdog_q + 1'b1;
                err_d  = err_q | (wdog_q == WW'(WDOG - 1));
                if (flush) state_d = du_finish ? S_IDLE : S_DRAIN;
                else if (du_finish) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_tag_d   = tag_q;
                    rsp_res_d   = du_res;
                    rsp_flags_d = du_flags;
                    state_d     = S_RESP;
                end
            end
            S_DRAIN: if (du_finish) state_d = S_IDLE;
            S_RESP: if (flush || rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
                if (!flush) rr_ptr_d = int'(rsp_id_q) == NREQ - 1 ? '0 : rsp_id_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            tag_q       <= '0;
            frs1_q      <= '0;
            frs2_q      <= '0;
            ftype_q     <= 1'b0;
            fctl_q      <= 1'b0;
            rm_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_tag_q   <= '0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
            wdog_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            tag_q       <= tag_d;
            frs1_q      <= frs1_d;
            frs2_q      <= frs2_d;
            ftype_q     <= ftype_d;
            fctl_q      <= fctl_d;
            rm_q        <= rm_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
            wdog_q      <= wdog_d;
            err_q       <= err_d;
        end
    end
endmodule
